// File: rtl/fp_switch_conditioner_if.sv
// Front-panel switch conditioner bus: raw switch levels and repeat enables in,
// debounced levels, edge pulses, press pulses and busy out.
interface fp_switch_conditioner_if #(
   parameter int NUM_CH = 16
);
   logic [NUM_CH-1:0] sw_raw;
   logic [NUM_CH-1:0] repeat_mask;
   logic [NUM_CH-1:0] sw_level;
   logic [NUM_CH-1:0] sw_rise;
   logic [NUM_CH-1:0] sw_fall;
   logic [NUM_CH-1:0] sw_press;
   logic              busy;

   // Source of raw switches (panel / testbench side)
   modport master (
      output sw_raw, repeat_mask,
      input  sw_level, sw_rise, sw_fall, sw_press, busy
   );

   // Conditioner side
   modport slave (
      input  sw_raw, repeat_mask,
      output sw_level, sw_rise, sw_fall, sw_press, busy
   );
endinterface

// File: rtl/fp_switch_conditioner.sv
// Multi-channel front-panel switch conditioner.
// Per channel: 2-flop synchronizer, counter debounce, registered rise/fall/press
// pulses. Auto-repeat on held switches is built only when FP_SW_AUTOREPEAT_EN is
// defined; otherwise sw_press equals sw_rise and repeat_mask is ignored.
// Repeat timing pauses while a release is being debounced, so a switch that is
// already let go does not emit further repeats before sw_level falls.

// One independent switch channel.
module fp_sw_channel #(
   parameter int   DEBOUNCE_CYCLES = 500000,
   parameter int   REPEAT_DELAY    = 25000000,
   parameter int   REPEAT_RATE     = 5000000,
   parameter logic RST_LVL         = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   input  logic mask,
   output logic level,
   output logic rise,
   output logic fall,
   output logic press,
   output logic busy
);
   localparam int            DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [DW-1:0] DTC = DW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s2_q;
   logic [DW-1:0] dcnt_d, dcnt_q;
   logic          level_d, level_q;
   logic          rise_d, rise_q, fall_d, fall_q, press_d, press_q;
   logic          rep_d;

   // Two-flop synchronizer; loads the reset level so release causes no edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= RST_LVL;
         s2_q <= RST_LVL;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
      end
   end

   // Debounce: accept s2 once it has disagreed for DEBOUNCE_CYCLES edges
   always_comb begin
      dcnt_d  = dcnt_q;
      level_d = level_q;
      if (s2_q == level_q) begin
         dcnt_d = '0;
      end else if (dcnt_q == DTC) begin
         level_d = s2_q;
         dcnt_d  = '0;
      end else begin
         dcnt_d = dcnt_q + 1'b1;
      end
      rise_d  = level_d & ~level_q;
      fall_d  = ~level_d & level_q;
      press_d = rise_d | rep_d;
   end

   // Debounce state and registered pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dcnt_q  <= '0;
         level_q <= RST_LVL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         press_q <= 1'b0;
      end else begin
         dcnt_q  <= dcnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         press_q <= press_d;
      end
   end

`ifdef FP_SW_AUTOREPEAT_EN
   typedef enum logic [1:0] {IDLE, WAIT_FIRST, REPEAT} rpt_state_t;

   localparam int            RMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int            RW      = (RMAX > 1) ? $clog2(RMAX + 1) : 1;
   localparam logic [RW-1:0] DLY_TC  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_TC = RW'(REPEAT_RATE - 1);
   localparam logic [RW-1:0] RCAP    = {RW{1'b1}};

   rpt_state_t    state_d, state_q;
   logic [RW-1:0] rcnt_d, rcnt_q, rcnt_inc;
   logic          mask_q;
   logic          hold;

   // Repeat FSM: next state, counter and repeat pulse
   always_comb begin
      state_d  = state_q;
      rcnt_d   = rcnt_q;
      rep_d    = 1'b0;
      hold     = (s2_q != level_q);
      rcnt_inc = (rcnt_q == RCAP) ? rcnt_q : rcnt_q + 1'b1;
      case (state_q)
         IDLE: begin
            if (mask && (rise_d || (level_q && !mask_q))) begin
               state_d = WAIT_FIRST;
               rcnt_d  = '0;
            end
         end
         WAIT_FIRST, REPEAT: begin
            if (!mask || !level_q) begin
               state_d = IDLE;
               rcnt_d  = '0;
            end else if (!hold) begin
               if (rcnt_q == ((state_q == WAIT_FIRST) ? DLY_TC : RATE_TC)) begin
                  rep_d   = 1'b1;
                  state_d = REPEAT;
                  rcnt_d  = '0;
               end else begin
                  rcnt_d = rcnt_inc;
               end
            end
         end
         default: begin
            state_d = IDLE;
            rcnt_d  = '0;
         end
      endcase
   end

   // Repeat FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rcnt_q  <= '0;
         mask_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         mask_q  <= mask;
      end
   end
`else
   localparam int unused_rpt = REPEAT_DELAY + REPEAT_RATE;
   logic unused_mask;
   assign unused_mask = mask;
   assign rep_d       = 1'b0;
`endif

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;
   assign press = press_q;
   assign busy  = (dcnt_q != '0);
endmodule

// Top: array of independent channels behind the conditioner interface.
module fp_switch_conditioner #(
   parameter int              NUM_CH          = 16,
   parameter int              DEBOUNCE_CYCLES = 500000,
   parameter int              REPEAT_DELAY    = 25000000,
   parameter int              REPEAT_RATE     = 5000000,
   parameter logic [NUM_CH-1:0] RESET_VAL     = '0
) (
   input logic                   clk,
   input logic                   reset,
   fp_switch_conditioner_if.slave bus
);
   logic [NUM_CH-1:0] level_w, rise_w, fall_w, press_w, busy_w;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      fp_sw_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE),
         .RST_LVL         (RESET_VAL[g])
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .raw   (bus.sw_raw[g]),
         .mask  (bus.repeat_mask[g]),
         .level (level_w[g]),
         .rise  (rise_w[g]),
         .fall  (fall_w[g]),
         .press (press_w[g]),
         .busy  (busy_w[g])
      );
   end

   assign bus.sw_level = level_w;
   assign bus.sw_rise  = rise_w;
   assign bus.sw_fall  = fall_w;
   assign bus.sw_press = press_w;
   assign bus.busy     = |busy_w;
endmodule

// File: tb/tb_fp_switch_conditioner.sv
// Directed bench for fp_switch_conditioner (NUM_CH=4, DEBOUNCE=8, DELAY=20, RATE=5).
// Expectations follow FP_SW_AUTOREPEAT_EN when it is defined for the build.
module tb_fp_switch_conditioner;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   fp_switch_conditioner_if #(.NUM_CH(4)) bus ();

   fp_switch_conditioner #(
      .NUM_CH(4), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(20), .REPEAT_RATE(5), .RESET_VAL(4'b0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected sw_press vector k edges after the accepted rise (k >= 1)
   function automatic logic [3:0] exp_press(input int k, input int last);
`ifdef FP_SW_AUTOREPEAT_EN
      return (k >= 20 && k <= last && ((k - 20) % 5) == 0) ? 4'b0100 : 4'b0000;
`else
      return 4'b0000;
`endif
   endfunction

   task automatic do_reset(input logic [3:0] raw);
      reset           = 1'b1;
      bus.sw_raw      = raw;
      bus.repeat_mask = 4'b0000;
      step();
      step();
      reset = 1'b0;
   endtask

   // Raise ch1 and ch2 (repeat enabled on ch2), return just after edge T
   task automatic start_hold();
      do_reset(4'b0000);
      bus.repeat_mask = 4'b0100;
      bus.sw_raw      = 4'b0110;
      repeat (9) step();
      chk("hold_lvl_pre", {28'd0, bus.sw_level}, 32'h0);
      step();
      chk("hold_lvl_T",   {28'd0, bus.sw_level}, 32'h6);
      chk("hold_rise_T",  {28'd0, bus.sw_rise},  32'h6);
      chk("hold_press_T", {28'd0, bus.sw_press}, 32'h6);
   endtask

   task automatic press_scan(input int from, input int to, input int last);
      for (int k = from; k <= to; k++) begin
         step();
         chk($sformatf("press_T+%0d", k), {28'd0, bus.sw_press}, {28'd0, exp_press(k, last)});
      end
   endtask

   initial begin
      // 1. reset with all switches closed, then release
      reset           = 1'b1;
      bus.sw_raw      = 4'b1111;
      bus.repeat_mask = 4'b0000;
      #2;
      chk("rst_level", {28'd0, bus.sw_level}, 32'h0);
      chk("rst_press", {28'd0, bus.sw_press}, 32'h0);
      chk("rst_busy",  {31'd0, bus.busy},     32'h0);
      step();
      step();
      chk("rst_hold_level", {28'd0, bus.sw_level}, 32'h0);
      reset = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         step();
         if (k == 5) chk("t1_busy", {31'd0, bus.busy}, 32'h1);
         if (k == 9) chk("t1_lvl9", {28'd0, bus.sw_level}, 32'h0);
         if (k == 10) begin
            chk("t1_lvl10",   {28'd0, bus.sw_level}, 32'hF);
            chk("t1_rise10",  {28'd0, bus.sw_rise},  32'hF);
            chk("t1_press10", {28'd0, bus.sw_press}, 32'hF);
            chk("t1_fall10",  {28'd0, bus.sw_fall},  32'h0);
         end
         if (k == 11) begin
            chk("t1_rise11", {28'd0, bus.sw_rise}, 32'h0);
            chk("t1_busy11", {31'd0, bus.busy},    32'h0);
         end
      end

      // 2. 5-cycle glitch on ch0 is rejected
      do_reset(4'b0000);
      bus.sw_raw = 4'b0001;
      for (int k = 1; k <= 12; k++) begin
         if (k == 6) bus.sw_raw = 4'b0000;
         step();
         if (k == 5) chk("t2_busy", {31'd0, bus.busy}, 32'h1);
         chk($sformatf("t2_lvl%0d", k),  {28'd0, bus.sw_level}, 32'h0);
         chk($sformatf("t2_rise%0d", k), {28'd0, bus.sw_rise},  32'h0);
      end
      chk("t2_busy_end", {31'd0, bus.busy}, 32'h0);

      // 3/4. held press on ch1 (no repeat) and ch2 (repeat)
      start_hold();
      press_scan(1, 41, 99);

      // 5. release ch2 at T+32: fall at T+42, no press after T+30
      start_hold();
      press_scan(1, 32, 30);
      bus.sw_raw = 4'b0010;
      for (int k = 33; k <= 45; k++) begin
         step();
         chk($sformatf("t5_press%0d", k), {28'd0, bus.sw_press}, 32'h0);
         chk($sformatf("t5_fall%0d", k), {28'd0, bus.sw_fall}, (k == 42) ? 32'h4 : 32'h0);
      end
      chk("t5_level", {28'd0, bus.sw_level}, 32'h2);

      // 6. clear repeat_mask[2] at T+22: no press after T+20
      start_hold();
      press_scan(1, 22, 20);
      bus.repeat_mask = 4'b0000;
      press_scan(23, 31, 20);

      // 7. async reset at T+22 clears outputs immediately
      start_hold();
      press_scan(1, 22, 20);
      reset = 1'b1;
      #1;
      chk("t7_level", {28'd0, bus.sw_level}, 32'h0);
      chk("t7_rise",  {28'd0, bus.sw_rise},  32'h0);
      chk("t7_fall",  {28'd0, bus.sw_fall},  32'h0);
      chk("t7_press", {28'd0, bus.sw_press}, 32'h0);
      chk("t7_busy",  {31'd0, bus.busy},     32'h0);
      step();
      chk("t7_level_hold", {28'd0, bus.sw_level}, 32'h0);
      reset = 1'b0;

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
